// File: rtl/i3c_pkg.sv
// rtl/i3c_pkg.sv - shared I3C constants and helpers for the TTI queues
package i3c_pkg;

    localparam int unsigned TtiTxQueueDepth = 64;
    localparam int unsigned TtiTxQueueWidth = 32;

    // Count fields need one extra bit so a full queue is distinct from an empty one.
    function automatic int unsigned tti_cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/tti_queue_mem.sv
// rtl/tti_queue_mem.sv - simple dual-port queue storage, sync write, async read
module tti_queue_mem #(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 64,
    localparam int unsigned AddrW = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             wr_en_i,
    input  logic [AddrW-1:0] wr_addr_i,
    input  logic [Width-1:0] wr_data_i,
    input  logic [AddrW-1:0] rd_addr_i,
    output logic [Width-1:0] rd_data_o
);

    // Kept free of reset so a technology SRAM wrapper can drop in later.
    logic [Width-1:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/tti_tx_queue.sv
// rtl/tti_tx_queue.sv - TTI TX word queue between CSR writes and the width converter
module tti_tx_queue
    import i3c_pkg::*;
#(
    parameter int unsigned Width = TtiTxQueueWidth,
    parameter int unsigned Depth = TtiTxQueueDepth,
    localparam int unsigned CntW = tti_cnt_width(Depth)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            wr_en_i,
    input  logic [Width-1:0] wr_data_i,
    output logic            rd_valid_o,
    input  logic            rd_ready_i,
    output logic [Width-1:0] rd_data_o,
    input  logic            flush_i,
    input  logic [CntW-1:0] thld_i,
    input  logic            clr_err_i,
    output logic [CntW-1:0] count_o,
    output logic            full_o,
    output logic            empty_o,
    output logic            thld_trig_o,
    output logic            overflow_o
);

    localparam int unsigned AddrW = $clog2(Depth);

    logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q, count_d, free_d;
    logic             full_q, empty_q, trig_q, ovf_q;
    logic             push, pop, ovf_set;

    // Full/empty decisions use registered flags, so a full queue rejects a push
    // even when a pop happens in the same cycle.
    assign push    = wr_en_i & ~full_q & ~flush_i;
    assign pop     = ~empty_q & rd_ready_i & ~flush_i;
    assign ovf_set = wr_en_i & full_q & ~flush_i;

    always_comb begin
        count_d = count_q;
        if (flush_i) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CntW'(1);
        end
    end

    assign free_d = CntW'(Depth) - count_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            trig_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            if (flush_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + AddrW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
            end
            count_q <= count_d;
            full_q  <= (count_d == CntW'(Depth));
            empty_q <= (count_d == '0);
            trig_q  <= (thld_i != '0) && (free_d >= thld_i);
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (clr_err_i) begin
                ovf_q <= 1'b0;
            end
        end
    end

    tti_queue_mem #(
        .Width (Width),
        .Depth (Depth)
    ) u_mem (
        .clk_i     (clk_i),
        .wr_en_i   (push),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (wr_data_i),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (rd_data_o)
    );

    assign rd_valid_o  = ~empty_q;
    assign count_o     = count_q;
    assign full_o      = full_q;
    assign empty_o     = empty_q;
    assign thld_trig_o = trig_q;
    assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_tti_tx_queue.sv
// tb/tb_tti_tx_queue.sv - scoreboard bench for tti_tx_queue
module tb_tti_tx_queue;

    localparam int Depth = 64;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        wr_en_i, rd_ready_i, flush_i, clr_err_i;
    logic [31:0] wr_data_i;
    logic        rd_valid_o;
    logic [31:0] rd_data_o;
    logic [6:0]  thld_i, count_o;
    logic        full_o, empty_o, thld_trig_o, overflow_o;

    int checks = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    bit          m_ovf, m_trig;

    tti_tx_queue dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .wr_en_i     (wr_en_i),
        .wr_data_i   (wr_data_i),
        .rd_valid_o  (rd_valid_o),
        .rd_ready_i  (rd_ready_i),
        .rd_data_o   (rd_data_o),
        .flush_i     (flush_i),
        .thld_i      (thld_i),
        .clr_err_i   (clr_err_i),
        .count_o     (count_o),
        .full_o      (full_o),
        .empty_o     (empty_o),
        .thld_trig_o (thld_trig_o),
        .overflow_o  (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Drive one cycle, check current outputs against the scoreboard at negedge,
    // then advance the scoreboard by what this cycle's inputs should do.
    task automatic step(input bit wr, input logic [31:0] d, input bit rdy,
                        input bit fl = 1'b0, input bit clr = 1'b0);
        bit full_pre;
        int sz;
        wr_en_i = wr; wr_data_i = d; rd_ready_i = rdy; flush_i = fl; clr_err_i = clr;
        @(negedge clk_i);
        sz = exp_q.size();
        chk("rd_valid", rd_valid_o, sz != 0);
        if (sz != 0) chk("rd_data", rd_data_o, exp_q[0]);
        chk("count", count_o, sz);
        chk("full", full_o, sz == Depth);
        chk("empty", empty_o, sz == 0);
        chk("overflow", overflow_o, m_ovf);
        chk("thld_trig", thld_trig_o, m_trig);
        full_pre = (sz == Depth);
        if (fl) begin
            exp_q.delete();
        end else begin
            if (rdy && sz != 0) void'(exp_q.pop_front());
            if (wr && !full_pre) exp_q.push_back(d);
        end
        if (wr && full_pre && !fl) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        m_trig = (thld_i != 0) && ((Depth - exp_q.size()) >= int'(thld_i));
        @(posedge clk_i);
        #1;
    endtask

    task automatic drain();
        while (exp_q.size() != 0) step(1'b0, 32'h0, 1'b1);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        exp_q.delete();
        m_ovf = 1'b0;
        m_trig = 1'b0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    initial begin
        wr_en_i = 0; wr_data_i = '0; rd_ready_i = 0; flush_i = 0; clr_err_i = 0; thld_i = '0;
        rst_i = 1'b0;
        #2;
        do_reset();
        chk("rst_count", count_o, 0);
        chk("rst_empty", empty_o, 1);
        chk("rst_full", full_o, 0);
        chk("rst_valid", rd_valid_o, 0);
        chk("rst_ovf", overflow_o, 0);
        chk("rst_trig", thld_trig_o, 0);
        for (int i = 0; i < 20; i++) step(1'b0, 32'h0, 1'b0);

        // Order and latency
        step(1'b1, 32'h11223344, 1'b1);
        chk("lat_valid", rd_valid_o, 1);
        chk("seq_count0", count_o, 1);
        step(1'b1, 32'h55667788, 1'b1);
        chk("seq_count1", count_o, 1);
        chk("seq_head", rd_data_o, 32'h55667788);
        step(1'b0, 32'h0, 1'b1);
        chk("seq_count2", count_o, 0);

        // Full, overflow, wrap
        for (int i = 0; i < Depth; i++) step(1'b1, 32'hA000_0000 + i, 1'b0);
        chk("full_flag", full_o, 1);
        chk("full_count", count_o, Depth);
        step(1'b1, 32'hBAD0_0001, 1'b0);
        chk("ovf_set", overflow_o, 1);
        step(1'b1, 32'hDEADBEEF, 1'b1);
        chk("full_pop_count", count_o, 63);
        drain();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < Depth; i++) step(1'b1, $urandom, 1'b0);
            drain();
        end

        // Simultaneous push/pop at count 5
        for (int i = 0; i < 5; i++) step(1'b1, 32'h5000 + i, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 32'h6000 + i, 1'b1);
        chk("pp_count", count_o, 5);
        drain();

        // Threshold
        thld_i = 7'd60;
        for (int i = 0; i < 4; i++) step(1'b1, 32'h7000 + i, 1'b0);
        chk("trig_at4", thld_trig_o, 1);
        step(1'b1, 32'h7004, 1'b0);
        chk("trig_at5", thld_trig_o, 0);
        thld_i = 7'd0;
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0);
        chk("trig_off", thld_trig_o, 0);
        drain();

        // Flush with concurrent push and pop; overflow still set from above
        for (int i = 0; i < 10; i++) step(1'b1, 32'h8000 + i, 1'b0);
        step(1'b1, 32'h9999_9999, 1'b1, 1'b1);
        chk("flush_count", count_o, 0);
        chk("flush_valid", rd_valid_o, 0);
        chk("flush_ovf", overflow_o, 1);
        step(1'b1, 32'hCAFEF00D, 1'b0);
        chk("flush_head", rd_data_o, 32'hCAFEF00D);
        drain();

        // Overflow set beats clear, then clear
        for (int i = 0; i < Depth; i++) step(1'b1, 32'hC000_0000 + i, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("ovf_clr", overflow_o, 0);
        step(1'b1, 32'hC0DE, 1'b0, 1'b0, 1'b1);
        chk("ovf_set_wins", overflow_o, 1);

        // Reset mid-operation
        do_reset();
        chk("midrst_count", count_o, 0);
        chk("midrst_valid", rd_valid_o, 0);
        chk("midrst_ovf", overflow_o, 0);
        step(1'b1, 32'h1234_5678, 1'b1);
        step(1'b0, 32'h0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/tti_tx_queue.md
Name: tti_tx_queue

Overview:
- Word-wide TX data queue between the TTI TX data register (CSR write side) and the N-to-8 width converter that feeds the I3C target FSM.
- Firmware pushes Width-bit words with fire-and-forget write strobes; the converter pops words over a valid/ready handshake.
- Provides occupancy, a free-space threshold trigger, a sticky overflow error and a synchronous flush.

Parameters:
- Width, 32, data word width in bits; multiple of 8.
- Depth, 64, number of entries; power of 2, >= 2.
- CntW, $clog2(Depth)+1, width of count and threshold fields (derived, not overridable).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- wr_en_i  in  1  one-cycle push strobe from CSR write
- wr_data_i  in  Width  push data
- rd_valid_o  out  1  head word available
- rd_ready_i  in  1  consumer accepts head word
- rd_data_o  out  Width  head word
- flush_i  in  1  synchronous queue clear
- thld_i  in  CntW  free-space threshold in entries; 0 disables
- clr_err_i  in  1  clears overflow_o
- count_o  out  CntW  current occupancy
- full_o  out  1  count_o == Depth
- empty_o  out  1  count_o == 0
- thld_trig_o  out  1  free-space threshold met
- overflow_o  out  1  sticky: push attempted while full

Behaviour:
- Reset (rst_i high, async): write/read pointers = 0, count_o = 0, empty_o = 1, full_o = 0, rd_valid_o = 0, overflow_o = 0, thld_trig_o = 0. rd_data_o is don't-care while rd_valid_o = 0. Storage is not reset.
- Reset mid-operation: all contents are discarded; the queue is empty the cycle after rst_i deasserts.
- Push: accepted when wr_en_i = 1, full_o = 0 and flush_i = 0. Data is written at the write pointer and the write pointer increments modulo Depth.
- Pop handshake: rd_valid_o & rd_ready_i. The read pointer increments modulo Depth.
- rd_valid_o = ~empty_o. rd_data_o = storage[rd_ptr], first-word-fall-through, read combinationally from registered pointers.
- Latency: a word pushed in cycle t is presented on rd_valid_o/rd_data_o in cycle t+1.
- rd_valid_o, once high, stays high and rd_data_o stays stable until the handshake or a flush.
- Count update: +1 on push only, −1 on pop only, unchanged when both occur.
- Full decision: uses the registered full_o. A push while full is rejected even if a pop occurs in the same cycle.
- Empty decision: uses the registered empty_o. A push into an empty queue cannot be popped in the same cycle.
- Pointers are $clog2(Depth) bits and wrap naturally. count_o is tracked separately, so count_o == Depth is distinguishable from 0.
- Overflow: wr_en_i & full_o & ~flush_i sets overflow_o in the next cycle.
  - clr_err_i clears it.
  - Set wins over clear in the same cycle.
  - Flush does not clear overflow_o.
- Threshold: thld_trig_o = (thld_i != 0) & ((Depth − count_o) >= thld_i).
  - Registered: reflects the count after this cycle's update, one cycle later.
  - thld_i > Depth never triggers.
- Flush: highest priority.
  - Next cycle: pointers = 0, count_o = 0, rd_valid_o = 0.
  - A concurrent push is dropped and does not count as overflow.
  - A concurrent pop handshake has no further effect.
  - The same flush_i also drives the width converter's flush so no partial word survives downstream.
- No internal FSM beyond pointer/count state. All outputs except rd_data_o are registered or derived from registered state.

Decomposition:
- Shared package (i3c_pkg): TTI queue default depth/width constants and the derived count width helper.
- One natural sub-module: tti_queue_mem, simple dual-port storage.
  - Parameters: Width, Depth.
  - Synchronous write port; asynchronous read port addressed by rd_ptr.
  - Keeps the array replaceable by a technology SRAM wrapper later.

Test Plan:
- Reset then idle: rst_i pulse → count_o=0, empty_o=1, rd_valid_o=0, overflow_o=0, thld_trig_o=0; rd_valid_o stays low for 20 cycles with no stimulus.
- Order and latency: push 0x11223344, 0x55667788 on consecutive cycles, rd_ready_i=1 → rd_valid_o rises the cycle after the first push; words pop in order; count_o sequence 1,1,0.
- Full/overflow/wrap (Depth=64): 64 pushes → full_o=1, count_o=64.
  - 65th push → rejected, overflow_o=1 next cycle.
  - Pop one while pushing 0xDEADBEEF → the push is rejected and count_o=63.
  - Drain and refill 3× → data is intact across the pointer wrap.
- Simultaneous push/pop at count_o=5 for 10 cycles → count_o stays 5; output order is preserved.
- Threshold: thld_i=60.
  - At count_o=4 → thld_trig_o=1.
  - Push once → count_o=5 and thld_trig_o=0 the following cycle.
  - thld_i=0 → thld_trig_o stays 0.
- Flush: with count_o=10, assert flush_i together with wr_en_i and a pop → next cycle count_o=0, rd_valid_o=0, overflow_o unchanged; the next push of 0xCAFEF00D is the head word.
